rv_alu: RTL and testbench
=========================

// Module: rv_alu
// PURPOSE
//  RV32I integer ALU in the CPU execute stage. Computes the selected operation on two
//  32-bit operands as a combinational path, with a zero flag.
//  Also provides a registered copy of the result and flags for pipeline/debug use.
//  Opcode macros come from defines.v (`ALU_*).
// PARAMETERS
//  XLEN        32   datapath width; only 32 is supported
// PORTS
//  clk         in   1     single clock; rising-edge
//  rst         in   1     synchronous, active-high reset
//  operand_a   in   32    rs1 / PC operand
//  operand_b   in   32    rs2 / immediate operand
//  alu_op      in   4     operation select (`ALU_* encoding below)
//  alu_result  out  32    combinational result
//  zero_flag   out  1     combinational; 1 when alu_result == 0
//  result_q    out  32    alu_result registered on clk
//  zero_q      out  1     zero_flag registered on clk
//  ovf_q       out  1     registered signed overflow of ADD/SUB; 0 for other ops
// BEHAVIOUR
//  Opcode encoding (defines.v):
//   0 ADD   a+b, mod 2^32
//   1 SUB   a-b, mod 2^32, computed as a+~b+1
//   2 SLL   a << b[4:0]
//   3 SLT   {31'b0, $signed(a) < $signed(b)}
//   4 SLTU  {31'b0, a < b}, unsigned
//   5 XOR   a^b
//   6 SRL   a >> b[4:0], logical
//   7 SRA   a >>> b[4:0], sign-filled
//   8 OR    a|b
//   9 AND   a&b
//   10 PASSB b (LUI)
//   11-15   undefined codes; result 0
//  - alu_result/zero_flag are purely combinational: no latches, zero cycle latency.
//    They settle within one evaluation of the inputs and do not depend on clk or rst.
//  - Shift amount uses b[4:0] only; b[31:5] is ignored. Shift of 0 returns a unchanged.
//  - Overflow flag:
//    ADD: ovf = (a[31]==b[31]) && (r[31]!=a[31])
//    SUB: ovf = (a[31]!=b[31]) && (r[31]!=a[31])
//  - Registered path: on each rising clk, result_q<=alu_result, zero_q<=zero_flag,
//    ovf_q<=ovf. There is no enable, so the registers update every cycle.
//  - Reset values: rst=1 at a rising edge gives result_q=0, zero_q=1, ovf_q=0.
//    Reset has priority over input capture.
//  - Reset mid-operation affects only the registered outputs; the combinational
//    outputs keep tracking the inputs.
//  - No carries are kept beyond 32 bits. SUB wraps on borrow, e.g.
//    0x00000000-0x00000001 = 0xFFFFFFFF.
//  - SLT and SLTU return 0 when a==b.
//  - SRA of 0x80000000 by 31 gives 0xFFFFFFFF.
// TESTING
//  SUB 0x401e1042-0x7fffffff -> alu_result=0xc01e1043, zero_flag=0
//  SUB 0xc41f1efb-0xec66e522 -> 0xd7b839d9 (borrow wrap)
//  SUB 0xd980edb4-0x7fffffff -> 0x5980edb5; SUB 0x12345678-0x12345678 -> 0, zero_flag=1
//  ADD 0x7fffffff+1 -> 0x80000000, ovf_q=1 after next clk
//  SLT 0xffffffff,1 -> 1; SLTU same operands -> 0
//  SRA 0x80000000 by 0x24 (amount 4) -> 0xf8000000
//  Assert rst for 1 clk mid-stream -> result_q=0, zero_q=1, ovf_q=0;
//  alu_result still tracks the inputs

Source files
------------

// File: rtl/rv_alu_if.sv
// Execute-stage ALU bus: operands and opcode in, combinational and registered results out.
interface rv_alu_if #(
   parameter int XLEN = 32
);
   logic [XLEN-1:0] operand_a;
   logic [XLEN-1:0] operand_b;
   logic [3:0]      alu_op;
   logic [XLEN-1:0] alu_result;
   logic            zero_flag;
   logic [XLEN-1:0] result_q;
   logic            zero_q;
   logic            ovf_q;

   // Issuer side: drives operands/opcode, observes results.
   modport master (
      output operand_a, operand_b, alu_op,
      input  alu_result, zero_flag, result_q, zero_q, ovf_q
   );

   // ALU side.
   modport slave (
      input  operand_a, operand_b, alu_op,
      output alu_result, zero_flag, result_q, zero_q, ovf_q
   );
endinterface

// File: rtl/rv_alu.sv
// RV32I integer ALU: combinational result and zero flag, plus a registered
// copy of result, zero and signed ADD/SUB overflow for pipeline/debug use.
module rv_alu #(
   parameter int XLEN = 32
) (
   input  logic    clk,
   input  logic    rst,
   rv_alu_if.slave bus
);
   localparam logic [3:0] ALU_ADD   = 4'd0;
   localparam logic [3:0] ALU_SUB   = 4'd1;
   localparam logic [3:0] ALU_SLL   = 4'd2;
   localparam logic [3:0] ALU_SLT   = 4'd3;
   localparam logic [3:0] ALU_SLTU  = 4'd4;
   localparam logic [3:0] ALU_XOR   = 4'd5;
   localparam logic [3:0] ALU_SRL   = 4'd6;
   localparam logic [3:0] ALU_SRA   = 4'd7;
   localparam logic [3:0] ALU_OR    = 4'd8;
   localparam logic [3:0] ALU_AND   = 4'd9;
   localparam logic [3:0] ALU_PASSB = 4'd10;

   logic [XLEN-1:0] w_a;
   logic [XLEN-1:0] w_b;
   logic [4:0]      w_shamt;
   logic [XLEN-1:0] w_sum;
   logic [XLEN-1:0] w_diff;
   logic [XLEN-1:0] w_result;
   logic            w_zero;
   logic            w_ovf;

   logic [XLEN-1:0] r_result_q;
   logic            r_zero_q;
   logic            r_ovf_q;

   assign w_a     = bus.operand_a;
   assign w_b     = bus.operand_b;
   // Only the low five bits select the shift distance; upper bits are ignored.
   assign w_shamt = w_b[4:0];
   assign w_sum   = w_a + w_b;
   // Subtraction as a + ~b + 1 so the borrow simply wraps mod 2^32.
   assign w_diff  = w_a + ~w_b + {{(XLEN-1){1'b0}}, 1'b1};

   // Operation select; unused opcodes 11-15 yield zero.
   always_comb begin
      w_result = '0;
      unique case (bus.alu_op)
         ALU_ADD:   w_result = w_sum;
         ALU_SUB:   w_result = w_diff;
         ALU_SLL:   w_result = w_a << w_shamt;
         ALU_SLT:   w_result = {{(XLEN-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
         ALU_SLTU:  w_result = {{(XLEN-1){1'b0}}, (w_a < w_b)};
         ALU_XOR:   w_result = w_a ^ w_b;
         ALU_SRL:   w_result = w_a >> w_shamt;
         ALU_SRA:   w_result = $unsigned($signed(w_a) >>> w_shamt);
         ALU_OR:    w_result = w_a | w_b;
         ALU_AND:   w_result = w_a & w_b;
         ALU_PASSB: w_result = w_b;
         default:   w_result = '0;
      endcase
   end

   assign w_zero = (w_result == '0);

   // Signed overflow is only meaningful for ADD/SUB; every other op reports 0.
   always_comb begin
      w_ovf = 1'b0;
      if (bus.alu_op == ALU_ADD)
         w_ovf = (w_a[XLEN-1] == w_b[XLEN-1]) && (w_sum[XLEN-1] != w_a[XLEN-1]);
      else if (bus.alu_op == ALU_SUB)
         w_ovf = (w_a[XLEN-1] != w_b[XLEN-1]) && (w_diff[XLEN-1] != w_a[XLEN-1]);
   end

   // Free-running capture of result and flags; reset wins and leaves a "zero" result.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_result_q <= '0;
         r_zero_q   <= 1'b1;
         r_ovf_q    <= 1'b0;
      end else begin
         r_result_q <= w_result;
         r_zero_q   <= w_zero;
         r_ovf_q    <= w_ovf;
      end
   end

   assign bus.alu_result = w_result;
   assign bus.zero_flag  = w_zero;
   assign bus.result_q   = r_result_q;
   assign bus.zero_q     = r_zero_q;
   assign bus.ovf_q      = r_ovf_q;
endmodule

// File: tb/tb_rv_alu.sv
// Scoreboard bench for rv_alu: directed vectors with hand-computed results.
module tb_rv_alu;
   logic clk;
   logic rst;

   rv_alu_if #(.XLEN(32)) u_if ();

   rv_alu #(.XLEN(32)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  op;
      logic        rst;
      logic [31:0] res;
      logic        zero;
      logic        ovf;
   } item_t;

   item_t sb_q[$];
   int    errors = 0;
   int    checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Drive one vector at the falling edge and record what the DUT must show.
   task automatic apply(input logic r, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res, input logic ovf);
      item_t it;
      @(negedge clk);
      rst            = r;
      u_if.alu_op    = op;
      u_if.operand_a = a;
      u_if.operand_b = b;
      it.a = a; it.b = b; it.op = op; it.rst = r;
      it.res = res; it.zero = (res == 32'h0); it.ovf = ovf;
      sb_q.push_back(it);
   endtask

   // Monitor: after each rising edge, compare combinational and registered outputs.
   initial begin
      item_t it;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            check($sformatf("alu_result op%0d a=%08h b=%08h", it.op, it.a, it.b),
                  u_if.alu_result, it.res);
            check($sformatf("zero_flag op%0d a=%08h b=%08h", it.op, it.a, it.b),
                  {31'b0, u_if.zero_flag}, {31'b0, it.zero});
            check($sformatf("result_q op%0d rst=%0d", it.op, it.rst),
                  u_if.result_q, it.rst ? 32'h0 : it.res);
            check($sformatf("zero_q op%0d rst=%0d", it.op, it.rst),
                  {31'b0, u_if.zero_q}, it.rst ? 32'h1 : {31'b0, it.zero});
            check($sformatf("ovf_q op%0d rst=%0d", it.op, it.rst),
                  {31'b0, u_if.ovf_q}, it.rst ? 32'h0 : {31'b0, it.ovf});
         end
      end
   end

   initial begin
      int budget;
      rst            = 1'b1;
      u_if.alu_op    = 4'd0;
      u_if.operand_a = 32'h0;
      u_if.operand_b = 32'h0;

      // Reset state, with the combinational path still live.
      apply(1'b1, 4'd0, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0);
      apply(1'b1, 4'd0, 32'h00000005, 32'h00000006, 32'h0000000b, 1'b0);

      // ADD / SUB including wrap and overflow corners.
      apply(1'b0, 4'd1, 32'h401e1042, 32'h7fffffff, 32'hc01e1043, 1'b0);
      apply(1'b0, 4'd1, 32'hc41f1efb, 32'hec66e522, 32'hd7b839d9, 1'b0);
      apply(1'b0, 4'd1, 32'hd980edb4, 32'h7fffffff, 32'h5980edb5, 1'b1);
      apply(1'b0, 4'd1, 32'h12345678, 32'h12345678, 32'h00000000, 1'b0);
      apply(1'b0, 4'd1, 32'h00000000, 32'h00000001, 32'hffffffff, 1'b0);
      apply(1'b0, 4'd1, 32'h80000000, 32'h00000001, 32'h7fffffff, 1'b1);
      apply(1'b0, 4'd0, 32'hffffffff, 32'h00000001, 32'h00000000, 1'b0);
      apply(1'b0, 4'd0, 32'h7fffffff, 32'h00000001, 32'h80000000, 1'b1);

      // Reset for one cycle mid-stream while an overflowing ADD is presented.
      apply(1'b1, 4'd0, 32'h7fffffff, 32'h00000001, 32'h80000000, 1'b1);
      apply(1'b0, 4'd0, 32'h00000003, 32'h00000004, 32'h00000007, 1'b0);

      // Compares.
      apply(1'b0, 4'd3, 32'hffffffff, 32'h00000001, 32'h00000001, 1'b0);
      apply(1'b0, 4'd4, 32'hffffffff, 32'h00000001, 32'h00000000, 1'b0);
      apply(1'b0, 4'd3, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0);
      apply(1'b0, 4'd4, 32'h00000001, 32'hffffffff, 32'h00000001, 1'b0);

      // Shifts: only b[4:0] counts.
      apply(1'b0, 4'd7, 32'h80000000, 32'h00000024, 32'hf8000000, 1'b0);
      apply(1'b0, 4'd7, 32'h80000000, 32'h0000001f, 32'hffffffff, 1'b0);
      apply(1'b0, 4'd6, 32'h80000000, 32'h00000024, 32'h08000000, 1'b0);
      apply(1'b0, 4'd2, 32'h00000001, 32'h0000003f, 32'h80000000, 1'b0);
      apply(1'b0, 4'd2, 32'h12345678, 32'h00000020, 32'h12345678, 1'b0);

      // Logic ops, PASSB and undefined codes.
      apply(1'b0, 4'd5, 32'hf0f0f0f0, 32'hff00ff00, 32'h0ff00ff0, 1'b0);
      apply(1'b0, 4'd8, 32'hf0f0f0f0, 32'hff00ff00, 32'hfff0fff0, 1'b0);
      apply(1'b0, 4'd9, 32'hf0f0f0f0, 32'hff00ff00, 32'hf000f000, 1'b0);
      apply(1'b0, 4'd10, 32'h11111111, 32'hdeadbeef, 32'hdeadbeef, 1'b0);
      apply(1'b0, 4'd11, 32'h00000001, 32'h00000002, 32'h00000000, 1'b0);
      apply(1'b0, 4'd15, 32'hffffffff, 32'hffffffff, 32'h00000000, 1'b0);

      budget = 20;
      while (sb_q.size() > 0 && budget > 0) begin
         @(posedge clk);
         budget--;
      end
      #3;
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
